// File: rtl/ahb_timer_reloader.sv
`default_nettype none
// ============================================================================
// Module  : ahb_timer_reloader
// Brief   : AHB3-Lite master that periodically reprograms MTIMECMP0. It keeps
//           a 64-bit shadow compare value and, on each timeout, adds the period
//           and rewrites the compare register with the glitch-free ACLINT
//           sequence HI=all-ones, LO, HI.
//           Optional build macro AHB_RELOADER_PARITY_EN enables address and
//           control parity on m_hparity_o. When it is undefined, that output
//           is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_timer_reloader #(
  parameter logic [31:0] TIMER_BASE = 32'h0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        enable_i,
  input  logic        start_i,
  input  logic [63:0] init_cmp_i,
  input  logic [31:0] period_i,
  input  logic        timeout_i,
  output logic [31:0] m_haddr_o,
  output logic [31:0] m_hwdata_o,
  output logic [1:0]  m_htrans_o,
  output logic        m_hwrite_o,
  output logic [2:0]  m_hsize_o,
  output logic [2:0]  m_hburst_o,
  output logic [3:0]  m_hprot_o,
  output logic        m_hmastlock_o,
  output logic [5:0]  m_hparity_o,
  input  logic        m_hready_i,
  input  logic        m_hresp_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] ticks_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_A_HIMAX = 3'd1;
  localparam logic [2:0] S_A_LO    = 3'd2;
  localparam logic [2:0] S_A_HI    = 3'd3;
  localparam logic [2:0] S_D_LAST  = 3'd4;
  localparam logic [2:0] S_GUARD   = 3'd5;
  localparam logic [2:0] S_ERR1    = 3'd6;

  localparam logic [31:0] C_ADDR_LO     = TIMER_BASE + 32'd8;
  localparam logic [31:0] C_ADDR_HI     = TIMER_BASE + 32'd12;
  localparam logic [1:0]  C_HTRANS_IDLE = 2'b00;
  localparam logic [1:0]  C_HTRANS_NSEQ = 2'b10;

  logic [2:0]  r_state;
  logic [63:0] r_shadow;
  logic        r_shadow_vld;
  logic        r_reload;
  logic [31:0] r_hwdata;
  logic        r_err;
  logic [31:0] r_ticks;

  logic [1:0]  w_htrans;
  logic [31:0] w_haddr;
  logic        w_data_err;

  // A data phase errors on the first cycle of the two-cycle ERROR response.
  assign w_data_err = m_hresp_i & ~m_hready_i;

  // Sequence controller: shadow update, pipelined write data, tick and error tracking.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_state      <= S_IDLE;
      r_shadow     <= 64'd0;
      r_shadow_vld <= 1'b0;
      r_reload     <= 1'b0;
      r_hwdata     <= 32'd0;
      r_err        <= 1'b0;
      r_ticks      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_shadow     <= init_cmp_i;
            r_shadow_vld <= 1'b1;
            r_reload     <= 1'b0;
            r_err        <= 1'b0;
            r_state      <= S_A_HIMAX;
          end else if (enable_i && timeout_i && r_shadow_vld && !r_err) begin
            r_shadow <= r_shadow + {32'd0, period_i};
            r_reload <= 1'b1;
            r_state  <= S_A_HIMAX;
          end
        end
        // No data phase is outstanding here, so only hready matters.
        S_A_HIMAX: begin
          if (m_hready_i) begin
            r_hwdata <= 32'hFFFF_FFFF;
            r_state  <= S_A_LO;
          end
        end
        S_A_LO: begin
          if (w_data_err) begin
            r_err   <= 1'b1;
            r_state <= S_ERR1;
          end else if (m_hready_i) begin
            r_hwdata <= r_shadow[31:0];
            r_state  <= S_A_HI;
          end
        end
        S_A_HI: begin
          if (w_data_err) begin
            r_err   <= 1'b1;
            r_state <= S_ERR1;
          end else if (m_hready_i) begin
            r_hwdata <= r_shadow[63:32];
            r_state  <= S_D_LAST;
          end
        end
        S_D_LAST: begin
          if (w_data_err) begin
            r_err   <= 1'b1;
            r_state <= S_ERR1;
          end else if (m_hready_i) begin
            r_ticks <= r_ticks + {31'd0, r_reload};
            r_state <= S_GUARD;
          end
        end
        // Lets the timer's new compare value settle before timeout is looked at again.
        S_GUARD: r_state <= S_IDLE;
        // Second cycle of the ERROR response; the bus is left idle.
        S_ERR1: begin
          if (m_hready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address-phase decode: only the three address states issue NONSEQ transfers.
  always_comb begin
    w_htrans = C_HTRANS_IDLE;
    w_haddr  = 32'd0;
    case (r_state)
      S_A_HIMAX: begin
        w_htrans = C_HTRANS_NSEQ;
        w_haddr  = C_ADDR_HI;
      end
      S_A_LO: begin
        w_htrans = C_HTRANS_NSEQ;
        w_haddr  = C_ADDR_LO;
      end
      S_A_HI: begin
        w_htrans = C_HTRANS_NSEQ;
        w_haddr  = C_ADDR_HI;
      end
      default: begin
        w_htrans = C_HTRANS_IDLE;
        w_haddr  = 32'd0;
      end
    endcase
  end

  assign m_haddr_o     = w_haddr;
  assign m_htrans_o    = w_htrans;
  assign m_hwdata_o    = r_hwdata;
  assign m_hwrite_o    = 1'b1;
  assign m_hsize_o     = 3'd2;
  assign m_hburst_o    = 3'd0;
  assign m_hprot_o     = 4'b0011;
  assign m_hmastlock_o = 1'b0;
  assign busy_o        = (r_state != S_IDLE);
  assign err_o         = r_err;
  assign ticks_o       = r_ticks;

`ifdef AHB_RELOADER_PARITY_EN
  assign m_hparity_o[0] = ^w_haddr[7:0];
  assign m_hparity_o[1] = ^w_haddr[15:8];
  assign m_hparity_o[2] = ^w_haddr[23:16];
  assign m_hparity_o[3] = ^w_haddr[31:24];
  assign m_hparity_o[4] = ^{m_hsize_o, m_hburst_o, m_hprot_o, m_hwrite_o, m_hmastlock_o};
  assign m_hparity_o[5] = ^w_htrans;
`else
  assign m_hparity_o = 6'd0;
`endif

endmodule
`default_nettype wire
